seg7_scan_ctrl: RTL and testbench

- Scan controller for the tile-mounted, common-anode, multiplexed 3-digit 7-segment display.
- Accepts a 12-bit hex value over a valid/ready handshake and holds it in a shadow register.
- Applies the shadow value tear-free at frame boundaries, then time-multiplexes digits with dead-time blanking and PWM brightness.
- Drives the digit-select (ca) and segment lines directly; replaces free-running scan logic at top level.

---
 rtl/seg7_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free shadow update and PWM dimming.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_ctrl #(
  parameter int NDIG      = 3,
  parameter int SLOT_CYC  = 8192,
  parameter int BLANK_CYC = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [3:0]        bright,
  output logic [NDIG-1:0]   ca,
  output logic [6:0]        seg,
  output logic              frame_tick
);

  localparam int SCW  = $clog2(SLOT_CYC);
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [SCW-1:0]  SLOT_LAST = SCW'(SLOT_CYC - 1);
  localparam logic [SCW-1:0]  BLANK_END = SCW'(BLANK_CYC);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

  logic [SCW-1:0]    slot_cnt;
  logic [IDXW-1:0]   idx;
  logic [4*NDIG-1:0] active;
  logic [4*NDIG-1:0] shadow;
  logic              pending;

  logic              slot_end;
  logic              frame_end;
  logic              blank;
  logic              lit;
  logic              lead_zero;
  logic [3:0]        nib;
  logic [NDIG-1:0]   ca_next;
  logic [6:0]        seg_next;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign blank     = (slot_cnt < BLANK_END);
  assign lit       = (slot_cnt[3:0] < bright);
  assign wr_ready  = !pending;

  always_comb begin
    nib       = '0;
    ca_next   = '1;
    lead_zero = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDXW'(i)) begin
        nib = active[4*i +: 4];
        ca_next[NDIG-1-i] = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead_zero = (i > 0) && ((active >> (4*i)) == '0);
`endif
      end
    end
    if (blank) ca_next = '1;
    seg_next = (!blank && lit && !lead_zero) ? font(nib) : 7'h00;
  end

  // Outputs are registered from the current counter state, so they lag it by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_cnt   <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      ca         <= '1;
      seg        <= 7'h00;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      ca         <= ca_next;
      seg        <= seg_next;
      frame_tick <= frame_end;
      // Apply only uses the pre-edge pending, so a write on the boundary waits a frame.
      if (frame_end && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (wr_valid && !pending) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl with a behavioural display model.
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 3;
  localparam int S     = 32;
  localparam int B     = 4;
  localparam int FRAME = NDIG * S;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam int LZ_LIT = 0;
`else
  localparam int LZ_LIT = 26;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_data = 12'h000;
  logic [3:0]  bright = 4'd15;
  logic [2:0]  ca;
  logic [6:0]  seg;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .SLOT_CYC(S), .BLANK_CYC(B)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .bright(bright), .ca(ca), .seg(seg), .frame_tick(frame_tick)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: the display state is a pure function of edges since release.
  logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          cnt = 0;
  logic [11:0] m_active = 0;
  logic [11:0] m_shadow = 0;
  bit          m_pending = 0;
  logic [2:0]  exp_ca = 3'b111;
  logic [6:0]  exp_seg = 0;
  bit          exp_ft = 0;
  int          m_slot, m_dig;
  bit          m_xfer, m_lz;
  logic [3:0]  m_nib;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt = 0; m_active = 0; m_shadow = 0; m_pending = 0;
      exp_ca = 3'b111; exp_seg = 0; exp_ft = 0;
    end else begin
      m_slot = cnt % S;
      m_dig  = (cnt / S) % NDIG;
      m_nib  = 4'((m_active >> (4 * m_dig)) & 12'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      m_lz = (m_dig > 0) && ((m_active >> (4 * m_dig)) == 0);
`else
      m_lz = 0;
`endif
      if (m_slot < B) begin
        exp_ca  = 3'b111;
        exp_seg = 0;
      end else begin
        exp_ca  = 3'(~(32'd1 << (NDIG - 1 - m_dig)));
        exp_seg = ((m_slot % 16) < int'(bright) && !m_lz) ? font[m_nib] : 7'h00;
      end
      exp_ft = (m_slot == S - 1) && (m_dig == NDIG - 1);
      m_xfer = wr_valid && !m_pending;
      if (exp_ft && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (m_xfer) begin
        m_shadow  = wr_data;
        m_pending = 1;
      end
      cnt++;
    end
  end

  always @(negedge clk) begin
    check("ca", 32'(ca), 32'(exp_ca));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_tick", 32'(frame_tick), 32'(exp_ft));
    check("wr_ready", 32'(wr_ready), 32'(!m_pending));
  end

  int first_ft;
  int n_lit, n_on, d0, d1, d2;
  bit got;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ca", 32'(ca), 32'h7);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_ready", 32'(wr_ready), 32'h1);
    resetn = 1'b1;

    // Power-up frame, then write 0x3A7 at edge 10.
    first_ft = -1;
    for (int e = 1; e <= 170; e++) begin
      @(negedge clk);
      if (e <= 4) check("blank_ca", 32'(ca), 32'h7);
      if (e == 5) begin
        check("d0_ca", 32'(ca), 32'h3);
        check("d0_zero", 32'(seg), 32'h3F);
      end
      if (frame_tick && first_ft < 0) first_ft = e;
      if (e == 10) begin wr_valid = 1'b1; wr_data = 12'h3A7; end
      if (e == 11) begin
        check("ready_low", 32'(wr_ready), 32'h0);
        wr_valid = 1'b0; wr_data = 12'hFFF;
      end
      if (e == 95) check("ready_still_low", 32'(wr_ready), 32'h0);
      if (e == 96) check("ready_back", 32'(wr_ready), 32'h1);
      if (e == 101) begin check("w_d0_ca", 32'(ca), 32'h3); check("w_d0_seg", 32'(seg), 32'h07); end
      if (e == 133) begin check("w_d1_ca", 32'(ca), 32'h5); check("w_d1_seg", 32'(seg), 32'h77); end
      if (e == 165) begin check("w_d2_ca", 32'(ca), 32'h6); check("w_d2_seg", 32'(seg), 32'h4F); end
    end
    check("first_frame_tick", 32'(first_ft), 32'd96);

    // Second write held while the first is pending.
    wr_valid = 1'b1; wr_data = 12'h123;
    @(negedge clk);
    wr_data = 12'h456;
    check("held_ready_low", 32'(wr_ready), 32'h0);
    got = 0;
    for (int k = 0; k < FRAME + 2; k++) begin
      @(negedge clk);
      if (wr_ready) begin got = 1; break; end
    end
    check("ready_rise_seen", 32'(got), 32'h1);
    check("ready_rise_phase", 32'(cnt % FRAME), 32'h0);
    @(negedge clk);
    wr_valid = 1'b0;
    check("second_accepted", 32'(wr_ready), 32'h0);
    repeat (2 * FRAME) @(negedge clk);

    // Brightness extremes.
    bright = 4'd0; n_lit = 0; n_on = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (seg != 0) n_lit++;
      if (ca != 3'b111) n_on++;
    end
    check("bright0_lit", 32'(n_lit), 32'd0);
    check("bright0_scan", 32'(n_on), 32'(FRAME - NDIG * B));
    bright = 4'd8; n_lit = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (seg != 0) n_lit++;
    end
    check("bright8_lit", 32'(n_lit), 32'd36);

    // Write landing exactly on the frame-boundary cycle.
    got = 0;
    for (int k = 0; k < FRAME + 1; k++) begin
      if (cnt % FRAME == FRAME - 1) begin got = 1; break; end
      @(negedge clk);
    end
    check("align_boundary", 32'(got), 32'h1);
    wr_valid = 1'b1; wr_data = 12'hB0C;
    @(negedge clk);
    wr_valid = 1'b0;
    check("bnd_pending", 32'(wr_ready), 32'h0);
    repeat (5) @(negedge clk);
    check("bnd_old_value", 32'(seg), 32'h7D);
    repeat (FRAME) @(negedge clk);
    check("bnd_new_value", 32'(seg), 32'h39);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 12'($urandom);
      if ($urandom_range(0, 15) == 0) bright = 4'($urandom);
    end
    wr_valid = 1'b0;

    // Reset in the middle of an ON phase with a write pending.
    bright = 4'd15;
    got = 0;
    for (int k = 0; k < FRAME + 2; k++) begin
      @(negedge clk);
      if (wr_ready) begin got = 1; break; end
    end
    check("pre_reset_ready", 32'(got), 32'h1);
    wr_valid = 1'b1; wr_data = 12'h9E1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("pre_reset_pending", 32'(wr_ready), 32'h0);
    for (int k = 0; k < S + 1; k++) begin
      if (cnt % S == 20) break;
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    check("async_ca", 32'(ca), 32'h7);
    check("async_seg", 32'(seg), 32'h0);
    check("async_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_d0", 32'(seg), 32'h3F);
    repeat (2 * FRAME) @(negedge clk);
    check("old_value_dropped", 32'(m_active), 32'h0);

    // Leading-zero behaviour with value 0x005.
    wr_valid = 1'b1; wr_data = 12'h005;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    d0 = 0; d1 = 0; d2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (ca == 3'b011 && seg != 0) d0++;
      if (ca == 3'b101 && seg != 0) d1++;
      if (ca == 3'b110 && seg != 0) d2++;
    end
    check("lz_d0_lit", 32'(d0), 32'd26);
    check("lz_d1_lit", 32'(d1), 32'(LZ_LIT));
    check("lz_d2_lit", 32'(d2), 32'(LZ_LIT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
